// File: rtl/framebuffer_arbiter.sv
// Arbitrates one single-port frame RAM between the pixel writer and the raster prefetcher,
// keeping a small show-ahead FIFO topped up for video_out.
module framebuffer_arbiter #(
    parameter int X_PX       = 800,
    parameter int Y_PX       = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_Wr_Valid,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [DATA_W-1:0] i_Wr_Data,
    output logic              o_Wr_Ready,
    input  logic              i_Pixel_Ack,
    output logic [DATA_W-1:0] o_Pixel_Data,
    output logic              o_Begin,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_We,
    output logic [DATA_W-1:0] o_Mem_Wdata,
    input  logic [DATA_W-1:0] i_Mem_Rdata,
    output logic              o_Underflow
);

    localparam int PIX   = X_PX * Y_PX;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CR_W  = CNT_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);
    localparam logic [ADDR_W:0]   PIX_EXT   = (ADDR_W + 1)'(PIX);
    localparam logic [CR_W-1:0]   DEPTH_C   = CR_W'(FIFO_DEPTH);
    localparam logic [CR_W-1:0]   LOW_C     = CR_W'(LOW_WATER);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                inflight_q;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]    fifo_wp_q, fifo_wp_d;
    logic [PTR_W-1:0]    fifo_rp_q, fifo_rp_d;
    logic [DATA_W-1:0]   head_q, head_d;
    logic                begin_q, begin_d;
    logic                under_q, under_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

    logic [CR_W-1:0]     credit;
    logic                rd_grant, wr_grant, wr_ready;
    logic                push, pop, wr_in_range;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;

    // Credit counts the in-flight read so the FIFO can never be overfilled.
    assign credit      = CR_W'(fifo_cnt_q) + CR_W'(inflight_q);
    assign push        = inflight_q;
    assign pop         = i_Pixel_Ack && (fifo_cnt_q != '0);
    assign wr_in_range = ({1'b0, i_Wr_Addr} < PIX_EXT);

    always_comb begin
        state_d  = state_q;
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        wr_ready = 1'b0;
        case (state_q)
            S_FILL: begin
                rd_grant = (credit < DEPTH_C);
                if (credit == DEPTH_C && !inflight_q) state_d = S_RUN;
            end
            default: begin
                if (credit < LOW_C) begin
                    rd_grant = 1'b1;
                end else begin
                    wr_ready = 1'b1;
                    if (i_Wr_Valid) wr_grant = 1'b1;
                    else            rd_grant = (credit < DEPTH_C);
                end
            end
        endcase
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (rd_grant) mem_addr = rd_ptr_q;
        if (wr_grant) begin
            mem_addr  = i_Wr_Addr;
            mem_wdata = i_Wr_Data;
            mem_we    = wr_in_range;
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_grant) rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);

        fifo_wp_d = push ? fifo_wp_q + PTR_W'(1) : fifo_wp_q;
        fifo_rp_d = pop  ? fifo_rp_q + PTR_W'(1) : fifo_rp_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // Head register mirrors the next FIFO entry; it holds when the FIFO drains.
        head_d = head_q;
        if (pop) begin
            if (fifo_cnt_q > CNT_W'(1)) head_d = fifo_mem[fifo_rp_q + PTR_W'(1)];
            else if (push)              head_d = i_Mem_Rdata;
        end else if (push && fifo_cnt_q == '0) begin
            head_d = i_Mem_Rdata;
        end

        begin_d = begin_q | (state_q == S_FILL && state_d == S_RUN);
        under_d = under_q | (i_Pixel_Ack && fifo_cnt_q == '0);
    end

    always_ff @(posedge i_CLK) begin
        if (push) fifo_mem[fifo_wp_q] <= i_Mem_Rdata;
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= S_FILL;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            fifo_cnt_q <= '0;
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            head_q     <= '0;
            begin_q    <= 1'b0;
            under_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= rd_grant;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_wp_q  <= fifo_wp_d;
            fifo_rp_q  <= fifo_rp_d;
            head_q     <= head_d;
            begin_q    <= begin_d;
            under_q    <= under_d;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
        end
    end

    assign o_Wr_Ready   = wr_ready;
    assign o_Pixel_Data = head_q;
    assign o_Begin      = begin_q;
    assign o_Mem_Addr   = mem_addr;
    assign o_Mem_We     = mem_we;
    assign o_Mem_Wdata  = mem_wdata;
    assign o_Underflow  = under_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter on a shrunken 8x4 frame with a behavioural frame RAM.
module tb_framebuffer_arbiter;

    localparam int X_PX   = 8;
    localparam int Y_PX   = 4;
    localparam int NPIX   = X_PX * Y_PX;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              pixel_ack;
    logic [DATA_W-1:0] pixel_data;
    logic              begin_o;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              underflow;

    int n_vec  = 0;
    int n_miss = 0;
    int we_cnt = 0;

    logic [DATA_W-1:0] ram     [NPIX];
    logic [DATA_W-1:0] exp_ram [NPIX];

    always #5 clk = ~clk;

    framebuffer_arbiter #(
        .X_PX(X_PX), .Y_PX(Y_PX), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FIFO_DEPTH(16), .LOW_WATER(8)
    ) dut (
        .i_CLK(clk),
        .i_RST_N(rst_n),
        .i_Wr_Valid(wr_valid),
        .i_Wr_Addr(wr_addr),
        .i_Wr_Data(wr_data),
        .o_Wr_Ready(wr_ready),
        .i_Pixel_Ack(pixel_ack),
        .o_Pixel_Data(pixel_data),
        .o_Begin(begin_o),
        .o_Mem_Addr(mem_addr),
        .o_Mem_We(mem_we),
        .o_Mem_Wdata(mem_wdata),
        .i_Mem_Rdata(mem_rdata),
        .o_Underflow(underflow)
    );

    function automatic logic [DATA_W-1:0] pat(input int a);
        return DATA_W'(a * 7 + 3);
    endfunction

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr < ADDR_W'(NPIX)) ram[mem_addr[4:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        mem_rdata <= ram[mem_addr[4:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_ready"}, 32'(wr_ready), 0);
        chk({tag, " begin"}, 32'(begin_o), 0);
        chk({tag, " we"}, 32'(mem_we), 0);
        chk({tag, " addr"}, 32'(mem_addr), 0);
        chk({tag, " wdata"}, 32'(mem_wdata), 0);
        chk({tag, " pixel"}, 32'(pixel_data), 0);
        chk({tag, " underflow"}, 32'(underflow), 0);
    endtask

    // Called at a negedge with reset asserted; releases it and walks the 19 FILL cycles.
    task automatic fill_run(input logic early_ack);
        rst_n     = 1'b1;
        pixel_ack = early_ack;
        wr_valid  = 1'b0;
        #1;
        chk("fill c0 addr", 32'(mem_addr), 0);
        chk("fill c0 we", 32'(mem_we), 0);
        chk("fill c0 underflow", 32'(underflow), 0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 2) pixel_ack = 1'b0;
            #1;
            if (c <= 15) chk($sformatf("fill c%0d addr", c), 32'(mem_addr), 32'(c));
            if (c == 1) begin
                chk("fill c1 pixel", 32'(pixel_data), 0);
                chk("fill c1 underflow", 32'(underflow), 32'(early_ack));
            end
            if (c == 17) chk("fill c17 begin", 32'(begin_o), 0);
            if (c == 18) begin
                chk("fill c18 begin", 32'(begin_o), 1);
                chk("fill c18 pixel", 32'(pixel_data), 32'(pat(0)));
                chk("fill c18 underflow", 32'(underflow), 32'(early_ack));
                chk("fill c18 wr_ready", 32'(wr_ready), 1);
            end
        end
        $display("fill phase done (early_ack=%0d)", early_ack);
    endtask

    initial begin
        for (int a = 0; a < NPIX; a++) begin
            ram[a]     = pat(a);
            exp_ram[a] = pat(a);
        end
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        pixel_ack = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        fill_run(1'b0);

        // Ack every cycle with a writer always pending: 9 writes, then the reader holds credit at 7.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            pixel_ack = 1'b1;
            wr_valid  = 1'b1;
            wr_addr   = ADDR_W'(12);
            wr_data   = 8'h5A;
            #1;
            if (i == 0) begin
                chk("run wr_ready", 32'(wr_ready), 1);
                chk("run we", 32'(mem_we), 1);
                chk("run addr", 32'(mem_addr), 12);
                chk("run wdata", 32'(mem_wdata), 32'h5A);
                exp_ram[12] = 8'h5A;
            end
            if (i == 20) begin
                chk("urgent wr_ready", 32'(wr_ready), 0);
                chk("urgent we", 32'(mem_we), 0);
            end
            chk($sformatf("pixel %0d", i), 32'(pixel_data),
                32'((i < NPIX) ? pat(i) : exp_ram[i - NPIX]));
        end
        @(negedge clk);
        pixel_ack = 1'b0;
        wr_valid  = 1'b0;
        #1;
        chk("run write count", 32'(we_cnt), 9);
        chk("run underflow", 32'(underflow), 0);
        $display("run phase done, %0d writes", we_cnt);

        repeat (20) @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(NPIX);
        wr_data  = 8'h33;
        #1;
        chk("oor wr_ready", 32'(wr_ready), 1);
        chk("oor we", 32'(mem_we), 0);
        @(negedge clk);
        wr_addr = ADDR_W'(5);
        wr_data = 8'hC3;
        #1;
        chk("oor write count", 32'(we_cnt), 9);
        chk("wr5 we", 32'(mem_we), 1);
        chk("wr5 addr", 32'(mem_addr), 5);
        chk("wr5 wdata", 32'(mem_wdata), 32'hC3);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("idle addr hold", 32'(mem_addr), 5);
        chk("idle we", 32'(mem_we), 0);
        $display("write range phase done");

        // Reset asserted between edges must clear every output at once.
        @(negedge clk);
        pixel_ack = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = ADDR_W'(7);
        wr_data   = 8'hEE;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        fill_run(1'b1);

        @(negedge clk);
        #1;
        chk("underflow sticky", 32'(underflow), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
